// File: rtl/darkbus_arb.sv
// -----------------------------------------------------------------------------
// darkbus_arb
//   Two-master, one-slave round-robin arbiter for the SoC memory port.
//   Master 0 is the core data port, master 1 the debug/DMA master. One
//   transaction is in flight at a time; a watchdog forces an error completion
//   if the slave never acknowledges.
//
// Ports
//   XCLK, XRES                 clock, asynchronous active-high reset
//   M0_*/M1_* (in)             REQ, WE, ADDR[AW], WDATA[DW], BE[DW/8]
//   M0_*/M1_* (out)            RDATA[DW] (valid with ACK), ACK (1-cycle pulse),
//                              ERR (with ACK on timeout completion)
//   S_REQ/S_WE/S_ADDR/S_WDATA/S_BE (out), S_RDATA/S_ACK (in)   slave side
//   GRANT[1:0]                 one-hot current owner, 00 when idle
// -----------------------------------------------------------------------------
module darkbus_arb #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int TMO = 255
) (
   input  logic            XCLK,
   input  logic            XRES,
   input  logic            M0_REQ,
   input  logic            M0_WE,
   input  logic [AW-1:0]   M0_ADDR,
   input  logic [DW-1:0]   M0_WDATA,
   input  logic [DW/8-1:0] M0_BE,
   output logic [DW-1:0]   M0_RDATA,
   output logic            M0_ACK,
   output logic            M0_ERR,
   input  logic            M1_REQ,
   input  logic            M1_WE,
   input  logic [AW-1:0]   M1_ADDR,
   input  logic [DW-1:0]   M1_WDATA,
   input  logic [DW/8-1:0] M1_BE,
   output logic [DW-1:0]   M1_RDATA,
   output logic            M1_ACK,
   output logic            M1_ERR,
   output logic            S_REQ,
   output logic            S_WE,
   output logic [AW-1:0]   S_ADDR,
   output logic [DW-1:0]   S_WDATA,
   output logic [DW/8-1:0] S_BE,
   input  logic [DW-1:0]   S_RDATA,
   input  logic            S_ACK,
   output logic [1:0]      GRANT
);

   localparam int CW = $clog2(TMO + 1);
   localparam logic [DW-1:0] TMO_DATA = DW'(32'hDEADBEEF);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [1:0]      grant;
   logic            last_owner;   // index of the master that owned the bus last
   logic [CW-1:0]   cnt;
   logic            ack0, ack1, err0, err1;
   logic [DW-1:0]   rdata0, rdata1;

   logic            owner_req;
   logic            pick_m1;
   logic            cnt_hit;

   // The owner's live REQ: dropping it mid-transaction aborts at once.
   assign owner_req = (grant[0] & M0_REQ) | (grant[1] & M1_REQ);

   // On a tie the master that did not own the bus last wins.
   assign pick_m1   = M1_REQ & (~M0_REQ | ~last_owner);

   // Reached on the TMO-th BUSY cycle without an acknowledge.
   assign cnt_hit   = (cnt == CW'(TMO - 1));

   assign S_REQ    = (state == BUSY) & owner_req;
   assign GRANT    = grant;
   assign M0_ACK   = ack0;
   assign M1_ACK   = ack1;
   assign M0_ERR   = err0;
   assign M1_ERR   = err1;
   assign M0_RDATA = rdata0;
   assign M1_RDATA = rdata1;

   // Slave-side mux; driven to zero whenever nobody holds the grant.
   always_comb begin
      S_WE    = 1'b0;
      S_ADDR  = '0;
      S_WDATA = '0;
      S_BE    = '0;
      if (grant[0]) begin
         S_WE    = M0_WE;
         S_ADDR  = M0_ADDR;
         S_WDATA = M0_WDATA;
         S_BE    = M0_BE;
      end else if (grant[1]) begin
         S_WE    = M1_WE;
         S_ADDR  = M1_ADDR;
         S_WDATA = M1_WDATA;
         S_BE    = M1_BE;
      end
   end

   always_ff @(posedge XCLK or posedge XRES) begin
      if (XRES) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_owner <= 1'b1;
         cnt        <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         err0       <= 1'b0;
         err1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (M0_REQ | M1_REQ) begin
                  grant <= pick_m1 ? 2'b10 : 2'b01;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_req) begin
                  // Abort: no completion, but the turn still counts as used.
                  grant      <= 2'b00;
                  last_owner <= grant[1];
                  state      <= IDLE;
               end else if (S_ACK) begin
                  // A real acknowledge beats a coincident timeout.
                  ack0       <= grant[0];
                  ack1       <= grant[1];
                  if (grant[0]) rdata0 <= S_RDATA;
                  if (grant[1]) rdata1 <= S_RDATA;
                  grant      <= 2'b00;
                  last_owner <= grant[1];
                  state      <= DONE;
               end else begin
                  if (cnt != CW'(TMO)) cnt <= cnt + CW'(1);
                  if (cnt_hit) begin
                     ack0       <= grant[0];
                     ack1       <= grant[1];
                     err0       <= grant[0];
                     err1       <= grant[1];
                     if (grant[0]) rdata0 <= TMO_DATA;
                     if (grant[1]) rdata1 <= TMO_DATA;
                     grant      <= 2'b00;
                     last_owner <= grant[1];
                     state      <= DONE;
                  end
               end
            end
            DONE: state <= IDLE;
            default: begin
               grant <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_darkbus_arb.sv
module tb_darkbus_arb;

   logic        XCLK = 1'b0;
   logic        XRES = 1'b1;
   logic        M0_REQ = 1'b0, M1_REQ = 1'b0, M0_WE = 1'b0, M1_WE = 1'b0;
   logic [31:0] M0_ADDR = '0, M1_ADDR = '0, M0_WDATA = '0, M1_WDATA = '0;
   logic [3:0]  M0_BE = '0, M1_BE = '0;
   logic [31:0] M0_RDATA, M1_RDATA;
   logic        M0_ACK, M1_ACK, M0_ERR, M1_ERR;
   logic        S_REQ, S_WE;
   logic [31:0] S_ADDR, S_WDATA;
   logic [3:0]  S_BE;
   logic [31:0] S_RDATA = '0;
   logic        S_ACK = 1'b0;
   logic [1:0]  GRANT;

   int n_chk = 0;
   int n_fail = 0;

   darkbus_arb #(.AW(32), .DW(32), .TMO(8)) dut (
      .XCLK(XCLK), .XRES(XRES),
      .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
      .M0_BE(M0_BE), .M0_RDATA(M0_RDATA), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
      .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
      .M1_BE(M1_BE), .M1_RDATA(M1_RDATA), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
      .S_REQ(S_REQ), .S_WE(S_WE), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA),
      .S_BE(S_BE), .S_RDATA(S_RDATA), .S_ACK(S_ACK), .GRANT(GRANT)
   );

   always #5 XCLK = ~XCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   localparam logic [31:0] A0 = 32'h0000_0100, D0 = 32'h1111_0000;
   localparam logic [31:0] A1 = 32'h0000_2000, D1 = 32'hCAFE_F00D;
   localparam logic [3:0]  B0 = 4'hF, B1 = 4'b0011;

   typedef struct {
      logic [4:0]  in;      // {m0_req, m1_req, m0_we, m1_we, s_ack}
      logic [31:0] srd;
      logic [1:0]  eg;
      logic [1:0]  ereq_we; // {s_req, s_we}
      logic [31:0] eaddr;
      logic [31:0] ewd;
      logic [3:0]  ebe;
      logic [3:0]  eacks;   // {m0_ack, m0_err, m1_ack, m1_err}
      logic [31:0] erd0;
      logic [31:0] erd1;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic add_idle(input logic [4:0] in, input logic [31:0] srd,
                           input logic [3:0] acks, input logic [31:0] rd0, input logic [31:0] rd1);
      vt.push_back('{in, srd, 2'b00, 2'b00, 32'h0, 32'h0, 4'h0, acks, rd0, rd1});
   endtask

   task automatic add_m0r(input logic [4:0] in, input logic [31:0] srd,
                          input logic [3:0] acks, input logic [31:0] rd0, input logic [31:0] rd1);
      vt.push_back('{in, srd, 2'b01, 2'b10, A0, D0, B0, acks, rd0, rd1});
   endtask

   task automatic add_m1w(input logic [4:0] in, input logic [31:0] srd,
                          input logic [3:0] acks, input logic [31:0] rd0, input logic [31:0] rd1);
      vt.push_back('{in, srd, 2'b10, 2'b11, A1, D1, B1, acks, rd0, rd1});
   endtask

   initial begin
      int a0c, a1c;
      logic [1:0] prev_g;
      logic exp_m1;

      M0_ADDR = A0; M0_WDATA = D0; M0_BE = B0;
      M1_ADDR = A1; M1_WDATA = D1; M1_BE = B1;

      // single read, slave acks two cycles after S_REQ
      add_idle(5'b10000, 32'h0,        4'b0000, 32'h0, 32'h0);
      add_m0r (5'b10000, 32'h0,        4'b0000, 32'h0, 32'h0);
      add_m0r (5'b10000, 32'h0,        4'b0000, 32'h0, 32'h0);
      add_m0r (5'b10001, 32'h12345678, 4'b0000, 32'h0, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b1000, 32'h12345678, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b0000, 32'h12345678, 32'h0);
      // M1 write pass-through
      add_idle(5'b01010, 32'h0,        4'b0000, 32'h12345678, 32'h0);
      add_m1w (5'b01011, 32'h0,        4'b0000, 32'h12345678, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b0010, 32'h12345678, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b0000, 32'h12345678, 32'h0);
      // tie with M1 last owner: M0 first, M1 waits, then M1, then waiting M0
      add_idle(5'b11010, 32'h0,        4'b0000, 32'h12345678, 32'h0);
      add_m0r (5'b11011, 32'hA0A0A0A0, 4'b0000, 32'h12345678, 32'h0);
      add_idle(5'b01010, 32'h0,        4'b1000, 32'hA0A0A0A0, 32'h0);
      add_idle(5'b11010, 32'h0,        4'b0000, 32'hA0A0A0A0, 32'h0);
      add_m1w (5'b11011, 32'h0,        4'b0000, 32'hA0A0A0A0, 32'h0);
      add_idle(5'b10000, 32'h0,        4'b0010, 32'hA0A0A0A0, 32'h0);
      add_idle(5'b10000, 32'h0,        4'b0000, 32'hA0A0A0A0, 32'h0);
      add_m0r (5'b10001, 32'h5A5A5A5A, 4'b0000, 32'hA0A0A0A0, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b1000, 32'h5A5A5A5A, 32'h0);
      add_idle(5'b00000, 32'h0,        4'b0000, 32'h5A5A5A5A, 32'h0);

      // reset state
      repeat (2) @(negedge XCLK);
      #1;
      chk("rst_grant", 32'(GRANT), 32'h0);
      chk("rst_sreq",  32'(S_REQ), 32'h0);
      chk("rst_acks",  32'({M0_ACK, M0_ERR, M1_ACK, M1_ERR}), 32'h0);
      chk("rst_rdata0", M0_RDATA, 32'h0);
      chk("rst_rdata1", M1_RDATA, 32'h0);
      @(negedge XCLK);
      XRES = 1'b0;

      foreach (vt[i]) begin
         @(negedge XCLK);
         {M0_REQ, M1_REQ, M0_WE, M1_WE, S_ACK} = vt[i].in;
         S_RDATA = vt[i].srd;
         #1;
         chk($sformatf("v%0d_grant", i), 32'(GRANT), 32'(vt[i].eg));
         chk($sformatf("v%0d_sreq", i),  32'(S_REQ), 32'(vt[i].ereq_we[1]));
         chk($sformatf("v%0d_swe", i),   32'(S_WE),  32'(vt[i].ereq_we[0]));
         chk($sformatf("v%0d_saddr", i), S_ADDR,  vt[i].eaddr);
         chk($sformatf("v%0d_swdata", i), S_WDATA, vt[i].ewd);
         chk($sformatf("v%0d_sbe", i),   32'(S_BE), 32'(vt[i].ebe));
         chk($sformatf("v%0d_m0ack", i), 32'(M0_ACK), 32'(vt[i].eacks[3]));
         chk($sformatf("v%0d_m0err", i), 32'(M0_ERR), 32'(vt[i].eacks[2]));
         chk($sformatf("v%0d_m1ack", i), 32'(M1_ACK), 32'(vt[i].eacks[1]));
         chk($sformatf("v%0d_m1err", i), 32'(M1_ERR), 32'(vt[i].eacks[0]));
         chk($sformatf("v%0d_m0rdata", i), M0_RDATA, vt[i].erd0);
         chk($sformatf("v%0d_m1rdata", i), M1_RDATA, vt[i].erd1);
      end

      // contention from reset, zero-wait slave, four transactions each
      @(negedge XCLK);
      {M0_REQ, M1_REQ, M0_WE, M1_WE, S_ACK} = 5'b00000;
      XRES = 1'b1;
      #1;
      chk("rst2_rdata0", M0_RDATA, 32'h0);
      chk("rst2_grant", 32'(GRANT), 32'h0);
      @(negedge XCLK);
      XRES = 1'b0;
      a0c = 0; a1c = 0; prev_g = 2'b00; exp_m1 = 1'b0;
      for (int c = 0; c < 80 && (a0c + a1c) < 8; c++) begin
         @(negedge XCLK);
         M0_REQ = (a0c < 4);
         M1_REQ = (a1c < 4);
         S_ACK = 1'b0;
         S_RDATA = 32'h7000_0000 + 32'(c);
         #1;
         if (GRANT != 2'b00 && prev_g == 2'b00) begin
            chk("cont_grant_order", 32'(GRANT), exp_m1 ? 32'h2 : 32'h1);
            exp_m1 = ~exp_m1;
         end
         prev_g = GRANT;
         S_ACK = S_REQ;
         if (M0_ACK) a0c++;
         if (M1_ACK) a1c++;
      end
      chk("cont_m0_acks", 32'(a0c), 32'd4);
      chk("cont_m1_acks", 32'(a1c), 32'd4);

      // timeout: M0 read, slave silent
      @(negedge XCLK);
      M0_REQ = 1'b1; M1_REQ = 1'b0; S_ACK = 1'b0;
      #1;
      chk("tmo_idle_grant", 32'(GRANT), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge XCLK);
         #1;
         chk($sformatf("tmo_busy%0d_sreq", k), 32'(S_REQ), 32'h1);
         chk($sformatf("tmo_busy%0d_ack", k), 32'(M0_ACK), 32'h0);
      end
      @(negedge XCLK);
      M0_REQ = 1'b0; M1_REQ = 1'b1;
      #1;
      chk("tmo_ack",   32'(M0_ACK), 32'h1);
      chk("tmo_err",   32'(M0_ERR), 32'h1);
      chk("tmo_rdata", M0_RDATA, 32'hDEADBEEF);
      chk("tmo_sreq",  32'(S_REQ), 32'h0);
      chk("tmo_m1ack", 32'(M1_ACK), 32'h0);
      @(negedge XCLK);
      #1;
      chk("tmo_after_ack", 32'(M0_ACK), 32'h0);
      chk("tmo_after_err", 32'(M0_ERR), 32'h0);
      @(negedge XCLK);
      #1;
      chk("tmo_m1_grant", 32'(GRANT), 32'h2);
      chk("tmo_m1_sreq",  32'(S_REQ), 32'h1);
      S_ACK = 1'b1; S_RDATA = 32'h0BAD_F00D;
      @(negedge XCLK);
      M1_REQ = 1'b0; S_ACK = 1'b0;
      #1;
      chk("tmo_m1_ack",   32'(M1_ACK), 32'h1);
      chk("tmo_m1_err",   32'(M1_ERR), 32'h0);
      chk("tmo_m1_rdata", M1_RDATA, 32'h0BAD_F00D);

      // acknowledge on the timeout cycle wins
      @(negedge XCLK);
      M0_REQ = 1'b1;
      #1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge XCLK);
         #1;
         chk($sformatf("edge_busy%0d_sreq", k), 32'(S_REQ), 32'h1);
      end
      @(negedge XCLK);
      S_ACK = 1'b1; S_RDATA = 32'h600D_DA7A;
      #1;
      chk("edge_c8_ack", 32'(M0_ACK), 32'h0);
      @(negedge XCLK);
      S_ACK = 1'b0; M0_REQ = 1'b0;
      #1;
      chk("edge_ack",   32'(M0_ACK), 32'h1);
      chk("edge_err",   32'(M0_ERR), 32'h0);
      chk("edge_rdata", M0_RDATA, 32'h600D_DA7A);

      // abort by M1 with M0 pending
      @(negedge XCLK);
      M1_REQ = 1'b1;
      #1;
      chk("abt_idle_grant", 32'(GRANT), 32'h0);
      @(negedge XCLK);
      M0_REQ = 1'b1;
      #1;
      chk("abt_m1_grant", 32'(GRANT), 32'h2);
      chk("abt_m1_sreq",  32'(S_REQ), 32'h1);
      @(negedge XCLK);
      M1_REQ = 1'b0;
      #1;
      chk("abt_sreq_drop", 32'(S_REQ), 32'h0);
      @(negedge XCLK);
      #1;
      chk("abt_no_ack",  32'(M1_ACK), 32'h0);
      chk("abt_idle",    32'(GRANT), 32'h0);
      @(negedge XCLK);
      #1;
      chk("abt_m0_grant", 32'(GRANT), 32'h1);
      chk("abt_no_ack2",  32'(M1_ACK), 32'h0);
      S_ACK = 1'b1; S_RDATA = 32'h1357_9BDF;
      @(negedge XCLK);
      S_ACK = 1'b0; M0_REQ = 1'b0;
      #1;
      chk("abt_m0_ack",   32'(M0_ACK), 32'h1);
      chk("abt_m0_rdata", M0_RDATA, 32'h1357_9BDF);

      // asynchronous reset mid-BUSY
      @(negedge XCLK);
      M1_REQ = 1'b1;
      #1;
      @(negedge XCLK);
      #1;
      chk("ares_pre_grant", 32'(GRANT), 32'h2);
      chk("ares_pre_sreq",  32'(S_REQ), 32'h1);
      #2;
      XRES = 1'b1;
      #1;
      chk("ares_sreq",  32'(S_REQ), 32'h0);
      chk("ares_grant", 32'(GRANT), 32'h0);
      chk("ares_acks",  32'({M0_ACK, M0_ERR, M1_ACK, M1_ERR}), 32'h0);
      @(negedge XCLK);
      M0_REQ = 1'b1;
      #3;
      XRES = 1'b0;
      #1;
      chk("ares_rel_m1ack", 32'(M1_ACK), 32'h0);
      @(negedge XCLK);
      #1;
      chk("ares_tie_grant", 32'(GRANT), 32'h1);
      chk("ares_tie_m1ack", 32'(M1_ACK), 32'h0);
      M0_REQ = 1'b0; M1_REQ = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
